// File: rtl/addsub_seq.sv
// Multi-cycle adder/subtractor: processes CHUNK bits per clock, LSB slice first,
// with a valid/ready handshake on both the operand and the result side.
module addsub_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flag_z,
    output logic             flag_n
);

    localparam int unsigned N    = (CHUNK >= 1) ? WIDTH / CHUNK : 1;
    localparam int unsigned IDXW = (N > 1) ? $clog2(N) : 1;

    generate
        if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("addsub_seq: WIDTH must be a non-zero multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;      // effective operand: b or ~b
    logic              sub_q, sub_d;
    logic              carry_q, carry_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic              c_q, c_d, v_q, v_d, z_q, z_d, n_q, n_d;

    int unsigned       base;
    logic [CHUNK-1:0]  sl_a, sl_b;
    logic [CHUNK:0]    sum;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        res_d   = res_q;
        c_d     = c_q;
        v_d     = v_q;
        z_d     = z_q;
        n_d     = n_q;

        base = 32'(idx_q) * CHUNK;
        sl_a = a_q[base +: CHUNK];
        sl_b = b_q[base +: CHUNK];
        sum  = {1'b0, sl_a} + {1'b0, sl_b} + {{CHUNK{1'b0}}, carry_q};

        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d   = a;
                    b_d   = op[0] ? ~b : b;
                    sub_d = op[0];
                    case (op)
                        2'b00:   carry_d = 1'b0;
                        2'b01:   carry_d = 1'b1;
                        2'b10:   carry_d = cin;
                        default: carry_d = ~cin;
                    endcase
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d[base +: CHUNK] = sum[CHUNK-1:0];
                carry_d = sum[CHUNK];
                idx_d   = idx_q + 1'b1;
                if (idx_q == IDXW'(N - 1)) begin
                    // Last slice: its sum carries the result MSB and the final carry.
                    c_d     = sum[CHUNK] ^ sub_q;
                    n_d     = sum[CHUNK-1];
                    z_d     = (res_d == '0);
                    v_d     = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[CHUNK-1] != a_q[WIDTH-1]);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            res_q   <= '0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            res_q   <= res_d;
            c_q     <= c_d;
            v_q     <= v_d;
            z_q     <= z_d;
            n_q     <= n_d;
        end
    end

    assign result = res_q;
    assign flag_c = c_q;
    assign flag_v = v_q;
    assign flag_z = z_q;
    assign flag_n = n_q;

endmodule

// File: tb/tb_addsub_seq.sv
// Directed-vector bench for addsub_seq at WIDTH=8, CHUNK=4.
module tb_addsub_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a, b;
    logic [1:0] op;
    logic       cin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       flag_c, flag_v, flag_z, flag_n;

    int unsigned checks = 0;
    int unsigned errors = 0;

    localparam logic [1:0] OP_ADD = 2'b00, OP_SUB = 2'b01, OP_ADC = 2'b10, OP_SBB = 2'b11;

    addsub_seq #(.WIDTH(8), .CHUNK(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flag_c(flag_c), .flag_v(flag_v), .flag_z(flag_z), .flag_n(flag_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // flags packed as {C,V,Z,N}
    function automatic logic [3:0] flags();
        return {flag_c, flag_v, flag_z, flag_n};
    endfunction

    task automatic wait_done(input string tag, output int unsigned lat);
        lat = 0;
        while (!out_valid && lat < 10) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, lat, 2);
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [7:0] av,
                          input logic [7:0] bv, input logic ci,
                          input logic [7:0] exp_r, input logic [3:0] exp_f);
        int unsigned lat;
        out_ready = 1'b1;
        check({tag, "_rdy"}, in_ready, 1);
        in_valid = 1'b1; a = av; b = bv; op = o; cin = ci;
        tick();
        in_valid = 1'b0; a = 8'hAA; b = 8'h55; cin = ~ci;
        wait_done(tag, lat);
        check({tag, "_res"}, result, exp_r);
        check({tag, "_flg"}, flags(), exp_f);
        tick();
        check({tag, "_idle"}, {in_ready, out_valid}, 2'b10);
    endtask

    initial begin
        int unsigned lat;
        int unsigned seen;

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = '0; cin = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        check("rst_hs", {in_ready, out_valid}, 2'b10);
        check("rst_res", result, 0);
        check("rst_flg", flags(), 0);
        rst_n = 1'b1;
        tick();

        run_op("sub_05_03", OP_SUB, 8'h05, 8'h03, 1'b0, 8'h02, 4'b0000);
        run_op("sub_03_05", OP_SUB, 8'h03, 8'h05, 1'b0, 8'hFE, 4'b1001);
        run_op("sub_80_01", OP_SUB, 8'h80, 8'h01, 1'b0, 8'h7F, 4'b0100);
        run_op("add_ff_01", OP_ADD, 8'hFF, 8'h01, 1'b0, 8'h00, 4'b1010);
        run_op("adc_7f_00", OP_ADC, 8'h7F, 8'h00, 1'b1, 8'h80, 4'b0101);
        run_op("sbb_10_0f", OP_SBB, 8'h10, 8'h0F, 1'b1, 8'h00, 4'b0010);
        run_op("add_cin_ign", OP_ADD, 8'h01, 8'h01, 1'b1, 8'h02, 4'b0000);
        run_op("sub_cin_ign", OP_SUB, 8'h00, 8'h01, 1'b1, 8'hFF, 4'b1001);
        run_op("adc_ff_ff", OP_ADC, 8'hFF, 8'hFF, 1'b1, 8'hFF, 4'b1001);
        run_op("sbb_00_00", OP_SBB, 8'h00, 8'h00, 1'b1, 8'hFF, 4'b1001);
        run_op("sbb_no_bin", OP_SBB, 8'h10, 8'h0F, 1'b0, 8'h01, 4'b0000);

        // Backpressure in DONE with in_valid pulses that must be ignored
        out_ready = 1'b0;
        in_valid = 1'b1; a = 8'h12; b = 8'h34; op = OP_ADD; cin = 1'b0;
        tick();
        in_valid = 1'b0;
        wait_done("bp", lat);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = 8'hF0; b = 8'h0F; op = OP_SUB;
            tick();
            check("bp_hs", {in_ready, out_valid}, 2'b01);
            check("bp_res", result, 8'h46);
            check("bp_flg", flags(), 4'b0000);
        end
        // Release with in_valid held: the release edge must not accept
        a = 8'h01; b = 8'h02; op = OP_ADD; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        check("bubble_idle", {in_ready, out_valid}, 2'b10);
        tick();
        check("bubble_acc", in_ready, 0);
        in_valid = 1'b0;
        wait_done("bubble", lat);
        check("bubble_res", result, 8'h03);
        tick();

        // Reset mid-RUN abandons the operation
        in_valid = 1'b1; a = 8'h55; b = 8'h22; op = OP_ADD;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        out_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        check("midrst_hs", {in_ready, out_valid}, 2'b10);
        check("midrst_res", result, 0);
        check("midrst_flg", flags(), 0);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("midrst_noval", seen, 0);
        run_op("post_rst_add", OP_ADD, 8'h01, 8'h01, 1'b0, 8'h02, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/addsub_seq.md
ADDSUB_SEQ -- requirements
Module: addsub_seq

Interface
- REQ-001: Parameter WIDTH, default 8, operand and result width in bits.
- REQ-002: Parameter CHUNK, default 4, bits processed per clock cycle.
- REQ-003: clk  input  1  single clock; all state updates on its rising edge.
- REQ-004: rst_n  input  1  reset, synchronous and active-low.
- REQ-005: in_valid  input  1  operand set presented.
- REQ-006: in_ready  output  1  block can accept an operand set.
- REQ-007: a  input  WIDTH  first operand.
- REQ-008: b  input  WIDTH  second operand.
- REQ-009: op  input  2  operation: 00 ADD, 01 SUB, 10 ADC, 11 SBB.
- REQ-010: cin  input  1  carry-in for ADC, borrow-in for SBB; ignored for ADD and SUB.
- REQ-011: out_valid  output  1  result and flags valid.
- REQ-012: out_ready  input  1  consumer accepts the result.
- REQ-013: result  output  WIDTH  sum or difference, modulo 2^WIDTH.
- REQ-014: flag_c  output  1  carry-out for ADD/ADC; borrow for SUB/SBB.
- REQ-015: flag_v  output  1  signed two's-complement overflow.
- REQ-016: flag_z  output  1  result equals zero.
- REQ-017: flag_n  output  1  result MSB.

Function
- REQ-018: WIDTH SHALL be an integer multiple of CHUNK, with CHUNK >= 1; other values are an elaboration error.
- REQ-019: The FSM SHALL have three states, IDLE, RUN and DONE; in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
- REQ-020: IDLE -> RUN on an edge with in_valid=1; a, b, op and cin SHALL be registered on that edge; no other input sampling occurs.
- REQ-021: Subtraction SHALL be computed as a + ~b + c0, with c0 = 1 for SUB and c0 = ~cin for SBB; for ADD c0 = 0, and for ADC c0 = cin.
- REQ-022: In RUN, each clock edge SHALL process one CHUNK slice, LSB slice first, with the internal carry chained between slices; N = WIDTH/CHUNK slices in total.
- REQ-023: RUN -> DONE SHALL occur on the edge that processes slice N-1, so out_valid rises exactly N edges after the accepting edge (N=2 at defaults).
- REQ-024: flag_c SHALL be the final carry for ADD/ADC and its inverse for SUB/SBB (1 means a < b + borrow-in, unsigned).
- REQ-025: flag_v SHALL be 1 when both effective operands (a and b, or a and ~b) have equal MSBs and the result MSB differs.
- REQ-026: flag_z and flag_n SHALL be derived from the final result and SHALL be valid in the same cycle as out_valid.
- REQ-027: DONE -> IDLE SHALL occur on an edge with out_ready=1; while out_ready=0, result and all flags SHALL hold stable.
- REQ-028: A new operand SHALL NOT be accepted on the DONE -> IDLE edge; the earliest acceptance is the following edge, giving one idle bubble.
- REQ-029: in_valid asserted outside IDLE SHALL be ignored, with no state change.
- REQ-030: For CHUNK = WIDTH, RUN SHALL last one cycle, giving N=1.

Reset
- REQ-031: On an edge with rst_n=0, the state SHALL go to IDLE, in_ready SHALL be 1 after the edge, out_valid SHALL be 0, and result and all flags SHALL be 0.
- REQ-032: Reset during RUN or DONE SHALL abandon the operation; no out_valid SHALL appear for it.
- REQ-033: rst_n SHALL take priority over in_valid and out_ready on the same edge.

Verification (WIDTH=8, CHUNK=4, out_ready=1 unless stated)
- REQ-034: SUB a=0x05 b=0x03 -> result 0x02, C=0, V=0, Z=0, N=0, with out_valid 2 edges after acceptance.
- REQ-035: SUB a=0x03 b=0x05 -> result 0xFE, C=1, V=0, N=1; SUB a=0x80 b=0x01 -> result 0x7F, C=0, V=1.
- REQ-036: ADD a=0xFF b=0x01 -> result 0x00, C=1, V=0, Z=1; ADC a=0x7F b=0x00 cin=1 -> result 0x80, V=1, N=1.
- REQ-037: SBB a=0x10 b=0x0F cin=1 -> result 0x00, C=0, Z=1, covering the inter-slice borrow.
- REQ-038: Backpressure: hold out_ready=0 for 3 cycles in DONE -> result, flags and out_valid stay stable, in_ready stays 0, and in_valid pulses are ignored; release -> IDLE, and the next operand is accepted one edge later.
- REQ-039: rst_n=0 for one edge mid-RUN -> out_valid never asserts for that operation, in_ready=1, outputs 0; a following ADD 0x01+0x01 -> result 0x02.
